// File: rtl/key_debounce.sv
// key_debounce -- debounces a raw mechanical key and reports its level and
// press/release events.
//
// Parameters:
//   DB_CYCLES     consecutive stable synchronized samples needed to accept a
//                 level change (>= 2)
//   ACTIVE_LOW    1: pressed key drives key_in low; 0: pressed key drives it high
//   REPEAT_DELAY  cycles in PRESSED before the first auto-repeat pulse
//   REPEAT_PERIOD cycles between subsequent auto-repeat pulses
//
// Ports:
//   clk           clock, all state updates on posedge
//   rst_n         asynchronous active-low reset
//   key_in        raw, asynchronous, bouncing key input
//   key_level     debounced level, 1 = pressed (registered)
//   press_pulse   one-cycle pressed event (registered)
//   release_pulse one-cycle released event (registered)
//
// Optional feature: define KEY_DEBOUNCE_REPEAT_EN to enable auto-repeat of
// press_pulse while the key stays held. Without it REPEAT_DELAY and
// REPEAT_PERIOD only size the shared timer.
module key_debounce #(
    parameter int unsigned DB_CYCLES     = 1000000,
    parameter int unsigned ACTIVE_LOW    = 1,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic        REL_LVL = (ACTIVE_LOW != 0);
    localparam int unsigned MAX_A   = (DB_CYCLES > REPEAT_DELAY) ? DB_CYCLES : REPEAT_DELAY;
    localparam int unsigned MAX_CNT = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int unsigned TW      = $clog2(MAX_CNT + 1);
    localparam logic [TW-1:0] DB_LAST = TW'(DB_CYCLES - 1);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    logic [1:0]    sync;
    logic          k;
    logic [1:0]    state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          press_nx, release_nx;

    // Synchronizer resets to the released raw level so a key held across
    // reset release is seen as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= {2{REL_LVL}};
        else        sync <= {sync[0], key_in};
    end

    // Normalize to active-high: XOR with the released raw level.
    assign k = sync[1] ^ REL_LVL;

`ifdef KEY_DEBOUNCE_REPEAT_EN
    localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RP_LAST = TW'(REPEAT_PERIOD - 1);

    // rep_first selects the initial delay versus the steady repeat period;
    // it survives a RELEASE_WAIT glitch so re-entry restarts the same interval.
    logic rep_first, rep_first_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rep_first <= 1'b1;
        else        rep_first <= rep_first_nx;
    end
`endif

    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        press_nx   = 1'b0;
        release_nx = 1'b0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
        rep_first_nx = rep_first;
`endif
        case (state)
            IDLE: begin
                if (k) begin
                    state_nx = PRESS_WAIT;
                    timer_nx = '0;
                end
            end
            PRESS_WAIT: begin
                if (!k) begin
                    state_nx = IDLE;
                end else if (timer == DB_LAST) begin
                    state_nx = PRESSED;
                    timer_nx = '0;
                    press_nx = 1'b1;
`ifdef KEY_DEBOUNCE_REPEAT_EN
                    rep_first_nx = 1'b1;
`endif
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end
            PRESSED: begin
                if (!k) begin
                    state_nx = RELEASE_WAIT;
                    timer_nx = '0;
`ifdef KEY_DEBOUNCE_REPEAT_EN
                end else if (timer == (rep_first ? RD_LAST : RP_LAST)) begin
                    timer_nx     = '0;
                    press_nx     = 1'b1;
                    rep_first_nx = 1'b0;
                end else begin
                    timer_nx = timer + TW'(1);
`endif
                end
            end
            RELEASE_WAIT: begin
                if (k) begin
                    state_nx = PRESSED;
                    timer_nx = '0;
                end else if (timer == DB_LAST) begin
                    state_nx   = IDLE;
                    timer_nx   = '0;
                    release_nx = 1'b1;
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                timer_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nx;
            timer         <= timer_nx;
            key_level     <= (state_nx == PRESSED) || (state_nx == RELEASE_WAIT);
            press_pulse   <= press_nx;
            release_pulse <= release_nx;
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce -- directed self-checking bench for key_debounce with
// DB_CYCLES=4, ACTIVE_LOW=1, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point, so "step i" is the i-th edge after the input change.
module tb_key_debounce;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_in = 1'b1;
    logic key_level, press_pulse, release_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    key_debounce #(
        .DB_CYCLES    (4),
        .ACTIVE_LOW   (1),
        .REPEAT_DELAY (10),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_in       (key_in),
        .key_level    (key_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_key();
        key_in = 1'b1;
        repeat (12) step();
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        key_in = 1'b1;
        repeat (3) step();
        n_cmp++;
        if (key_level !== 1'b0) begin n_bad++; $display("FAIL reset_level got=%b exp=0", key_level); end
        n_cmp++;
        if (press_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_press got=%b exp=0", press_pulse); end
        n_cmp++;
        if (release_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_release got=%b exp=0", release_pulse); end
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            n_cmp++;
            if ({key_level, press_pulse, release_pulse} !== 3'b000) begin
                n_bad++;
                $display("FAIL idle_quiet step=%0d got=%b exp=000", i, {key_level, press_pulse, release_pulse});
            end
        end
    endtask

    task automatic test_clean_press();
        key_in = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            n_cmp++;
            if (press_pulse !== (i == 7)) begin
                n_bad++;
                $display("FAIL clean_press_pulse step=%0d got=%b exp=%b", i, press_pulse, (i == 7));
            end
            n_cmp++;
            if (key_level !== (i >= 7)) begin
                n_bad++;
                $display("FAIL clean_press_level step=%0d got=%b exp=%b", i, key_level, (i >= 7));
            end
        end
    endtask

    task automatic test_bounce();
        for (int c = 0; c < 20; c++) begin
            key_in = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
            step();
            n_cmp++;
            if ({key_level, press_pulse} !== 2'b00) begin
                n_bad++;
                $display("FAIL bounce_quiet cycle=%0d got=%b exp=00", c, {key_level, press_pulse});
            end
        end
        key_in = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            n_cmp++;
            if (press_pulse !== (i == 7)) begin
                n_bad++;
                $display("FAIL bounce_press_pulse step=%0d got=%b exp=%b", i, press_pulse, (i == 7));
            end
        end
    endtask

    // Entered in PRESSED: a 3-cycle release glitch must be swallowed.
    task automatic test_release_glitch();
        key_in = 1'b1;
        repeat (3) begin
            step();
            n_cmp++;
            if ({key_level, release_pulse} !== 2'b10) begin
                n_bad++;
                $display("FAIL glitch_hi got=%b exp=10", {key_level, release_pulse});
            end
        end
        key_in = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            n_cmp++;
            if ({key_level, release_pulse} !== 2'b10) begin
                n_bad++;
                $display("FAIL glitch_after step=%0d got=%b exp=10", i, {key_level, release_pulse});
            end
`ifndef KEY_DEBOUNCE_REPEAT_EN
            n_cmp++;
            if (press_pulse !== 1'b0) begin
                n_bad++;
                $display("FAIL glitch_press step=%0d got=%b exp=0", i, press_pulse);
            end
`endif
        end
    endtask

    task automatic test_full_release();
        key_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            n_cmp++;
            if (release_pulse !== (i == 7)) begin
                n_bad++;
                $display("FAIL release_pulse step=%0d got=%b exp=%b", i, release_pulse, (i == 7));
            end
            n_cmp++;
            if (key_level !== (i < 7)) begin
                n_bad++;
                $display("FAIL release_level step=%0d got=%b exp=%b", i, key_level, (i < 7));
            end
        end
    endtask

    // Modulo-10 counter enabled by press_pulse, 12 press/release cycles.
    task automatic test_counter();
        int cnt = 0;
        int co_seen = 0;
        int presses = 0;
        int both = 0;
        for (int p = 0; p < 12; p++) begin
            for (int ph = 0; ph < 2; ph++) begin
                key_in = (ph == 0) ? 1'b0 : 1'b1;
                repeat (10) begin
                    step();
                    if (press_pulse && release_pulse) both++;
                    if (press_pulse === 1'b1) begin
                        presses++;
                        if (cnt == 9) begin co_seen++; cnt = 0; end
                        else cnt++;
                    end
                end
            end
        end
        n_cmp++;
        if (presses !== 12) begin n_bad++; $display("FAIL counter_presses got=%0d exp=12", presses); end
        n_cmp++;
        if (cnt !== 2) begin n_bad++; $display("FAIL counter_cnt got=%0d exp=2", cnt); end
        n_cmp++;
        if (co_seen !== 1) begin n_bad++; $display("FAIL counter_co got=%0d exp=1", co_seen); end
        n_cmp++;
        if (both !== 0) begin n_bad++; $display("FAIL pulse_overlap got=%0d exp=0", both); end
    endtask

    task automatic test_reset_mid();
        // Reset in the press_pulse cycle, key kept held across reset.
        key_in = 1'b0;
        repeat (7) step();
        n_cmp++;
        if (press_pulse !== 1'b1) begin n_bad++; $display("FAIL midpulse_pre got=%b exp=1", press_pulse); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({key_level, press_pulse, release_pulse} !== 3'b000) begin
            n_bad++;
            $display("FAIL midpulse_async got=%b exp=000", {key_level, press_pulse, release_pulse});
        end
        step();
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            n_cmp++;
            if ({press_pulse, key_level} !== {(i == 7), (i >= 7)}) begin
                n_bad++;
                $display("FAIL held_across_reset step=%0d got=%b exp=%b", i,
                         {press_pulse, key_level}, {(i == 7), (i >= 7)});
            end
        end
        release_key();
        // Reset in PRESS_WAIT with the key held.
        key_in = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({key_level, press_pulse, release_pulse} !== 3'b000) begin
            n_bad++;
            $display("FAIL midwait_async got=%b exp=000", {key_level, press_pulse, release_pulse});
        end
        step();
        rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            n_cmp++;
            if (press_pulse !== (i == 7)) begin
                n_bad++;
                $display("FAIL midwait_press step=%0d got=%b exp=%b", i, press_pulse, (i == 7));
            end
        end
    endtask

    task automatic test_repeat();
        int extra = 0;
        int first_at = 0;
        int exp_extra;
        int exp_first;
`ifdef KEY_DEBOUNCE_REPEAT_EN
        exp_extra = 7;
        exp_first = 10;
`else
        exp_extra = 0;
        exp_first = 0;
`endif
        key_in = 1'b0;
        repeat (7) step();
        n_cmp++;
        if (press_pulse !== 1'b1) begin n_bad++; $display("FAIL repeat_initial got=%b exp=1", press_pulse); end
        for (int i = 1; i <= 30; i++) begin
            step();
            if (press_pulse === 1'b1) begin
                extra++;
                if (first_at == 0) first_at = i;
            end
        end
        n_cmp++;
        if (extra !== exp_extra) begin n_bad++; $display("FAIL repeat_count got=%0d exp=%0d", extra, exp_extra); end
        n_cmp++;
        if (first_at !== exp_first) begin n_bad++; $display("FAIL repeat_first got=%0d exp=%0d", first_at, exp_first); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        release_key();
        test_bounce();
        test_release_glitch();
        test_full_release();
        release_key();
        test_counter();
        release_key();
        test_reset_mid();
        release_key();
        test_repeat();
        release_key();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
